// File: rtl/tlul_req_arbiter.sv
// Round-robin arbiter that shares one TL-UL A/D channel pair between NREQ
// local requesters. Each requester may have one request in flight, and the
// A-channel source ID carries the requester index so D responses can be
// routed back.
module tlul_req_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int SW   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [3*NREQ-1:0]    i_req_opcode,
  input  logic [AW*NREQ-1:0]   i_req_address,
  input  logic [DW*NREQ-1:0]   i_req_data,
  input  logic [DW/8*NREQ-1:0] i_req_mask,
  output logic [NREQ-1:0]      o_rsp_valid,
  output logic [DW-1:0]        o_rsp_data,
  output logic                 o_rsp_error,
  output logic                 o_a_valid,
  input  logic                 i_a_ready,
  output logic [2:0]           o_a_opcode,
  output logic [2:0]           o_a_size,
  output logic [SW-1:0]        o_a_source,
  output logic [AW-1:0]        o_a_address,
  output logic [DW-1:0]        o_a_data,
  output logic [DW/8-1:0]      o_a_mask,
  input  logic                 i_d_valid,
  output logic                 o_d_ready,
  input  logic [SW-1:0]        i_d_source,
  input  logic [DW-1:0]        i_d_data,
  input  logic                 i_d_error,
  output logic                 o_proto_err
);

  localparam int MW = DW / 8;
  // Per-source tables are sized to the full source-ID space so any SW-bit
  // ID can index them; entries at or above NREQ read as zero.
  localparam int NS = 2 ** SW;
  localparam logic [2:0] A_SIZE = 3'($clog2(MW));

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e              state_q, state_d;
  logic                a_valid_q, a_valid_d;
  logic [2:0]          a_opcode_q, a_opcode_d;
  logic [2:0]          a_size_q, a_size_d;
  logic [SW-1:0]       a_source_q, a_source_d;
  logic [AW-1:0]       a_address_q, a_address_d;
  logic [DW-1:0]       a_data_q, a_data_d;
  logic [MW-1:0]       a_mask_q, a_mask_d;
  logic [NREQ-1:0]     outstanding_q, outstanding_d;
  logic [SW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]       rsp_data_q, rsp_data_d;
  logic                rsp_error_q, rsp_error_d;
  logic                proto_err_q, proto_err_d;

  logic [2:0]          req_opcode  [NS];
  logic [AW-1:0]       req_address [NS];
  logic [DW-1:0]       req_data    [NS];
  logic [MW-1:0]       req_mask    [NS];
  logic [NS-1:0]       eligible;
  logic [NS-1:0]       outstanding_pad;

  logic [NREQ-1:0]     grant;
  logic                win_found;
  logic [SW-1:0]       win_idx;
  logic [SW-1:0]       cand;
  int                  cand_i;
  logic                a_handshake;
  logic                d_ok;

  // Unpack the per-requester buses into source-indexed tables.
  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_unpack
      if (gi < NREQ) begin : g_real
        assign req_opcode[gi]      = i_req_opcode[gi*3 +: 3];
        assign req_address[gi]     = i_req_address[gi*AW +: AW];
        assign req_data[gi]        = i_req_data[gi*DW +: DW];
        assign req_mask[gi]        = i_req_mask[gi*MW +: MW];
        assign eligible[gi]        = i_req_valid[gi] & ~outstanding_q[gi];
        assign outstanding_pad[gi] = outstanding_q[gi];
      end else begin : g_pad
        assign req_opcode[gi]      = '0;
        assign req_address[gi]     = '0;
        assign req_data[gi]        = '0;
        assign req_mask[gi]        = '0;
        assign eligible[gi]        = 1'b0;
        assign outstanding_pad[gi] = 1'b0;
      end
    end
  endgenerate

  // Pick the winner, advance the FSM and track outstanding/response state.
  always_comb begin
    state_d       = state_q;
    a_valid_d     = a_valid_q;
    a_opcode_d    = a_opcode_q;
    a_size_d      = a_size_q;
    a_source_d    = a_source_q;
    a_address_d   = a_address_q;
    a_data_d      = a_data_q;
    a_mask_d      = a_mask_q;
    outstanding_d = outstanding_q;
    rr_ptr_d      = rr_ptr_q;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    proto_err_d   = proto_err_q;
    grant         = '0;
    win_found     = 1'b0;
    win_idx       = '0;
    cand          = '0;
    cand_i        = 0;

    // Scan from rr_ptr upward, wrapping at NREQ; rr_ptr is always < NREQ.
    for (int off = 0; off < NREQ; off++) begin
      cand_i = int'(rr_ptr_q) + off;
      if (cand_i >= NREQ) begin
        cand_i = cand_i - NREQ;
      end
      cand = SW'(cand_i);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end

    a_handshake = (state_q == S_ISSUE) && i_a_ready;
    // Sources >= NREQ read as not-outstanding, so they fail this test too.
    d_ok = i_d_valid && outstanding_pad[i_d_source];

    if (state_q == S_IDLE) begin
      if (win_found) begin
        state_d     = S_ISSUE;
        a_valid_d   = 1'b1;
        a_opcode_d  = req_opcode[win_idx];
        a_size_d    = A_SIZE;
        a_source_d  = win_idx;
        a_address_d = req_address[win_idx];
        a_data_d    = req_data[win_idx];
        a_mask_d    = req_mask[win_idx];
      end
    end else if (a_handshake) begin
      state_d   = S_IDLE;
      a_valid_d = 1'b0;
      rr_ptr_d  = (int'(a_source_q) == NREQ - 1) ? '0 : a_source_q + 1'b1;
    end

    if (i_d_valid) begin
      if (d_ok) begin
        rsp_data_d  = i_d_data;
        rsp_error_d = i_d_error;
      end else begin
        proto_err_d = 1'b1;
      end
    end

    for (int k = 0; k < NREQ; k++) begin
      grant[k] = (state_q == S_IDLE) && win_found && (win_idx == SW'(k));
      if (d_ok && (i_d_source == SW'(k))) begin
        rsp_valid_d[k]   = 1'b1;
        outstanding_d[k] = 1'b0;
      end
      if (a_handshake && (a_source_q == SW'(k))) begin
        outstanding_d[k] = 1'b1;
      end
    end
  end

  // Single state register for the FSM and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= S_IDLE;
      a_valid_q     <= 1'b0;
      a_opcode_q    <= '0;
      a_size_q      <= '0;
      a_source_q    <= '0;
      a_address_q   <= '0;
      a_data_q      <= '0;
      a_mask_q      <= '0;
      outstanding_q <= '0;
      rr_ptr_q      <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_valid_q     <= a_valid_d;
      a_opcode_q    <= a_opcode_d;
      a_size_q      <= a_size_d;
      a_source_q    <= a_source_d;
      a_address_q   <= a_address_d;
      a_data_q      <= a_data_d;
      a_mask_q      <= a_mask_d;
      outstanding_q <= outstanding_d;
      rr_ptr_q      <= rr_ptr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // The capture strobe must be combinational so a requester sees its
  // request taken in the same cycle; it is forced low while in reset.
  assign o_req_ready = grant & {NREQ{i_reset_n}};
  assign o_d_ready   = i_reset_n;
  assign o_a_valid   = a_valid_q;
  assign o_a_opcode  = a_opcode_q;
  assign o_a_size    = a_size_q;
  assign o_a_source  = a_source_q;
  assign o_a_address = a_address_q;
  assign o_a_data    = a_data_q;
  assign o_a_mask    = a_mask_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_error = rsp_error_q;
  assign o_proto_err = proto_err_q;

endmodule

// File: tb/tb_tlul_req_arbiter.sv
// Self-checking bench for tlul_req_arbiter (NREQ=2). A transaction-level
// reference model tracks pending issue, outstanding requesters, round-robin
// position and response pulses; every cycle the DUT outputs are compared
// against it, plus directed checks for the named scenarios.
module tb_tlul_req_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = 2;
  localparam int MW   = DW / 8;

  logic                 i_clk = 1'b0;
  logic                 i_reset_n;
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ-1:0]      o_req_ready;
  logic [3*NREQ-1:0]    i_req_opcode;
  logic [AW*NREQ-1:0]   i_req_address;
  logic [DW*NREQ-1:0]   i_req_data;
  logic [MW*NREQ-1:0]   i_req_mask;
  logic [NREQ-1:0]      o_rsp_valid;
  logic [DW-1:0]        o_rsp_data;
  logic                 o_rsp_error;
  logic                 o_a_valid;
  logic                 i_a_ready;
  logic [2:0]           o_a_opcode;
  logic [2:0]           o_a_size;
  logic [SW-1:0]        o_a_source;
  logic [AW-1:0]        o_a_address;
  logic [DW-1:0]        o_a_data;
  logic [MW-1:0]        o_a_mask;
  logic                 i_d_valid;
  logic                 o_d_ready;
  logic [SW-1:0]        i_d_source;
  logic [DW-1:0]        i_d_data;
  logic                 i_d_error;
  logic                 o_proto_err;

  tlul_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_opcode(i_req_opcode), .i_req_address(i_req_address),
    .i_req_data(i_req_data), .i_req_mask(i_req_mask),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_error(o_rsp_error),
    .o_a_valid(o_a_valid), .i_a_ready(i_a_ready), .o_a_opcode(o_a_opcode),
    .o_a_size(o_a_size), .o_a_source(o_a_source), .o_a_address(o_a_address),
    .o_a_data(o_a_data), .o_a_mask(o_a_mask),
    .i_d_valid(i_d_valid), .o_d_ready(o_d_ready), .i_d_source(i_d_source),
    .i_d_data(i_d_data), .i_d_error(i_d_error), .o_proto_err(o_proto_err)
  );

  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int hs_log[$];

  // Reference model state
  bit           m_busy;
  int           m_src;
  logic [2:0]   m_op;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [MW-1:0] m_mask;
  bit           m_out [NREQ];
  int           m_rr;
  bit           m_rsp_pend;
  int           m_rsp_src;
  logic [DW-1:0] m_rsp_data;
  bit           m_rsp_err;
  bit           m_perr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Round-robin rule: first requester at or after m_rr (mod NREQ) that is
  // asking and has nothing in flight; -1 when nobody qualifies.
  function automatic int model_winner();
    for (int off = 0; off < NREQ; off++) begin
      int k;
      k = (m_rr + off) % NREQ;
      if (i_req_valid[k] && !m_out[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit any_out();
    for (int k = 0; k < NREQ; k++) if (m_out[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_src = 0; m_rr = 0; m_rsp_pend = 0; m_perr = 0;
    for (int k = 0; k < NREQ; k++) m_out[k] = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int w;
    logic [63:0] exp_rdy;
    @(negedge i_clk);
    w = model_winner();
    exp_rdy = (i_reset_n && !m_busy && w >= 0) ? (64'd1 << w) : 64'd0;
    chk("req_ready", o_req_ready, exp_rdy);
    chk("a_valid", o_a_valid, m_busy);
    if (m_busy) begin
      chk("a_source", o_a_source, m_src);
      chk("a_opcode", o_a_opcode, m_op);
      chk("a_size", o_a_size, 2);
      chk("a_address", o_a_address, m_addr);
      chk("a_data", o_a_data, m_data);
      chk("a_mask", o_a_mask, m_mask);
    end
    chk("rsp_valid", o_rsp_valid, m_rsp_pend ? (64'd1 << m_rsp_src) : 64'd0);
    if (m_rsp_pend) begin
      chk("rsp_data", o_rsp_data, m_rsp_data);
      chk("rsp_error", o_rsp_error, m_rsp_err);
    end
    chk("proto_err", o_proto_err, m_perr);
    chk("d_ready", o_d_ready, i_reset_n);
    if (i_reset_n && o_a_valid && i_a_ready) hs_log.push_back(int'(o_a_source));
    @(posedge i_clk);
    if (!i_reset_n) begin
      model_reset();
    end else begin
      m_rsp_pend = 0;
      if (i_d_valid) begin
        if (int'(i_d_source) < NREQ && m_out[int'(i_d_source)]) begin
          m_rsp_pend = 1; m_rsp_src = int'(i_d_source);
          m_rsp_data = i_d_data; m_rsp_err = i_d_error;
          m_out[int'(i_d_source)] = 0;
        end else begin
          m_perr = 1;
        end
      end
      if (m_busy) begin
        if (i_a_ready) begin
          m_out[m_src] = 1;
          m_rr = (m_src + 1) % NREQ;
          m_busy = 0;
        end
      end else if (w >= 0) begin
        m_busy = 1; m_src = w;
        m_op   = i_req_opcode[w*3 +: 3];
        m_addr = i_req_address[w*AW +: AW];
        m_data = i_req_data[w*DW +: DW];
        m_mask = i_req_mask[w*MW +: MW];
      end
    end
    #1;
  endtask

  task automatic set_req(input int k, input logic [2:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [MW-1:0] mask);
    i_req_opcode[k*3 +: 3]    = op;
    i_req_address[k*AW +: AW] = addr;
    i_req_data[k*DW +: DW]    = data;
    i_req_mask[k*MW +: MW]    = mask;
  endtask

  task automatic rand_reqs();
    for (int k = 0; k < NREQ; k++)
      set_req(k, ($urandom_range(0, 1) != 0) ? 3'd4 : 3'd0, $urandom, $urandom, 4'($urandom));
  endtask

  task automatic d_send(input int src, input logic [DW-1:0] data, input logic err);
    i_d_valid = 1'b1; i_d_source = SW'(src); i_d_data = data; i_d_error = err;
  endtask

  task automatic d_none();
    i_d_valid = 1'b0; i_d_source = '0; i_d_data = '0; i_d_error = 1'b0;
  endtask

  // Answer the lowest-numbered outstanding requester, if any.
  task automatic respond_all();
    d_none();
    for (int k = NREQ - 1; k >= 0; k--)
      if (m_out[k]) d_send(k, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    i_req_valid = '0;
    i_a_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!m_busy && !any_out()) break;
      respond_all();
      cycle();
    end
    d_none();
    cycle();
    chk("drain_a_valid", o_a_valid, 0);
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    cycle();
    cycle();
    i_reset_n = 1'b1;
  endtask

  logic [AW-1:0] snap_addr;
  logic [SW-1:0] snap_src;

  initial begin
    i_reset_n = 1'b0; i_req_valid = '0; i_req_opcode = '0; i_req_address = '0;
    i_req_data = '0; i_req_mask = '0; i_a_ready = 1'b0;
    d_none();
    model_reset();
    @(posedge i_clk); #1;

    // Reset: a request during reset must not be captured.
    i_req_valid = 2'b01;
    cycle();
    cycle();
    chk("reset_a_size", o_a_size, 0);
    chk("reset_a_valid", o_a_valid, 0);
    chk("reset_req_ready", o_req_ready, 0);
    chk("reset_d_ready", o_d_ready, 0);
    i_req_valid = '0;
    i_reset_n = 1'b1;
    cycle();

    // Single Get from requester 0: capture in N, A valid in N+1.
    set_req(0, 3'd4, 32'h10, 32'h1234_5678, 4'hf);
    i_req_valid = 2'b01; i_a_ready = 1'b1;
    #1 chk("t1_req_ready_N", o_req_ready, 2'b01);
    cycle();
    i_req_valid = '0;
    chk("t1_a_valid", o_a_valid, 1);
    chk("t1_a_source", o_a_source, 0);
    chk("t1_a_opcode", o_a_opcode, 4);
    chk("t1_a_size", o_a_size, 2);
    chk("t1_a_address", o_a_address, 32'h10);
    cycle();
    drain();

    // Both requesters always asking, D answered immediately: 0,1,0,1.
    do_reset();
    rand_reqs();
    hs_log.delete();
    i_req_valid = 2'b11; i_a_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      respond_all();
      cycle();
    end
    chk("t2_hs_count_ge4", (hs_log.size() >= 4), 1);
    if (hs_log.size() >= 4) begin
      chk("t2_src0", hs_log[0], 0);
      chk("t2_src1", hs_log[1], 1);
      chk("t2_src2", hs_log[2], 0);
      chk("t2_src3", hs_log[3], 1);
    end
    drain();

    // a_ready held low for 5 cycles: fields frozen, no captures.
    i_a_ready = 1'b0;
    i_req_valid = 2'b11;
    rand_reqs();
    cycle();
    chk("t3_captured", o_a_valid, 1);
    snap_addr = m_addr; snap_src = SW'(m_src);
    for (int i = 0; i < 5; i++) begin
      rand_reqs();
      #1;
      chk("t3_hold_req_ready", o_req_ready, 0);
      chk("t3_hold_addr", o_a_address, snap_addr);
      chk("t3_hold_src", o_a_source, snap_src);
      cycle();
    end
    i_a_ready = 1'b1;
    i_req_valid = '0;
    cycle();
    drain();

    // Response routing to requester 1.
    set_req(1, 3'd0, 32'h40, 32'hCAFE_F00D, 4'hf);
    i_req_valid = 2'b10; i_a_ready = 1'b1;
    cycle();
    i_req_valid = '0;
    cycle();
    d_send(1, 32'hDEAD_BEEF, 1'b0);
    cycle();
    d_none();
    chk("t4_rsp_valid", o_rsp_valid, 2'b10);
    chk("t4_rsp_data", o_rsp_data, 32'hDEAD_BEEF);
    chk("t4_rsp_error", o_rsp_error, 0);
    cycle();
    chk("t4_rsp_pulse_end", o_rsp_valid, 0);
    drain();

    // Requester 0 blocked while outstanding; requester 1 still served.
    i_req_valid = 2'b01; i_a_ready = 1'b1;
    cycle();
    i_req_valid = '0;
    cycle();
    hs_log.delete();
    i_req_valid = 2'b11;
    for (int i = 0; i < 4; i++) cycle();
    chk("t5_hs_count", hs_log.size(), 1);
    if (hs_log.size() >= 1) chk("t5_hs_src", hs_log[0], 1);
    d_send(0, 32'h0BAD_CAFE, 1'b1);
    cycle();
    d_none();
    chk("t5_req0_ready_after_d", o_req_ready, 2'b01);
    cycle();
    drain();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rand_reqs();
      i_req_valid = NREQ'($urandom);
      i_a_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) begin
        d_none();
        for (int k = 0; k < NREQ; k++)
          if (m_out[k] && $urandom_range(0, 1) != 0) d_send(k, $urandom, 1'($urandom_range(0, 1)));
      end else begin
        d_none();
      end
      cycle();
    end
    drain();

    // Unexpected D responses: no pulse, sticky error until reset.
    d_send(1, 32'h1111_2222, 1'b0);
    cycle();
    d_none();
    chk("t7_perr_set", o_proto_err, 1);
    chk("t7_no_rsp", o_rsp_valid, 0);
    d_send(3, 32'h3333_4444, 1'b0);
    cycle();
    d_none();
    for (int i = 0; i < 3; i++) cycle();
    chk("t7_perr_sticky", o_proto_err, 1);
    i_reset_n = 1'b0;
    cycle();
    chk("t7_perr_cleared", o_proto_err, 0);
    i_reset_n = 1'b1;
    cycle();

    // Reset in the middle of an issue, then a stale D response.
    i_req_valid = 2'b10; i_a_ready = 1'b1;
    cycle();
    i_req_valid = 2'b01;
    cycle();
    i_a_ready = 1'b0;
    i_req_valid = 2'b01;
    cycle();
    i_req_valid = '0;
    cycle();
    chk("t8_issuing", o_a_valid, 1);
    i_reset_n = 1'b0;
    cycle();
    chk("t8_a_valid_drop", o_a_valid, 0);
    i_reset_n = 1'b1;
    d_send(1, 32'h5555_6666, 1'b0);
    cycle();
    d_none();
    chk("t8_late_perr", o_proto_err, 1);
    chk("t8_late_no_rsp", o_rsp_valid, 0);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
